// File: rtl/uart_secded_rx_fifo.sv
// uart_secded_rx_fifo
// -------------------
// Oversampling UART receiver for 8-bit frames that each carry a Hamming(7,4)
// codeword plus an overall parity bit. Each frame with a good stop bit is
// decoded with single-error correction and queued in a ready/valid FIFO.
//
// Optional feature macro: UART_SECDED_EN
//   defined   -> frame[7] is even overall parity; double errors are flagged
//                as uncorrectable and left uncorrected.
//   undefined -> frame[7] is ignored; any nonzero syndrome is corrected and
//                out_uncorrectable is tied to 0.
//
// Parameters
//   CLKS_PER_BIT  clocks per UART bit (even, >= 4)
//   FIFO_DEPTH    output FIFO entries (power of two, >= 2)
//
// Ports
//   clk               clock
//   rst               synchronous active-high reset
//   ena               global enable; low freezes all state
//   rx                asynchronous serial input, idle high
//   out_ready         consumer accepts the head entry
//   out_valid         FIFO non-empty
//   out_data          decoded nibble at FIFO head
//   out_syndrome      Hamming syndrome of head entry
//   out_corrected     head entry had an error that was fixed
//   out_uncorrectable head entry had a double error (SECDED build only)
//   fifo_count        FIFO occupancy
//   overflow          sticky; a frame was dropped because the FIFO was full
//   frame_err         one-cycle pulse after a bad stop bit
//   state_out         receiver state: IDLE=0, START=1, DATA=2, STOP=3
module uart_secded_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          rx,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [3:0]                    out_data,
  output logic [2:0]                    out_syndrome,
  output logic                          out_corrected,
  output logic                          out_uncorrectable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [1:0]                    state_out
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [CW-1:0]   HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LOAD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [CNTW-1:0] FIFO_FULL  = CNTW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] OCC_ONE    = CNTW'(1);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic           rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]     bit_idx, bit_idx_nxt;
  logic [7:0]     frame, frame_nxt;
  logic           stop_wait, stop_wait_nxt;
  logic           ferr_q, ferr_nxt;
  logic           push;
  logic           tick;

  // Two-flop synchroniser plus one extra delayed copy for falling-edge
  // detection; all flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else if (ena) begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick = (bit_cnt == '0);

  // Next-state and datapath controls. Sampling happens when the bit counter
  // reaches zero; START waits half a bit so later samples land mid-bit.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    bit_idx_nxt   = bit_idx;
    frame_nxt     = frame;
    stop_wait_nxt = stop_wait;
    push          = 1'b0;
    ferr_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_nxt   = START;
          bit_cnt_nxt = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_sync) begin
            state_nxt   = DATA;
            bit_cnt_nxt = BIT_LOAD;
            bit_idx_nxt = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (tick) begin
          frame_nxt   = {rx_sync, frame[7:1]};
          bit_cnt_nxt = BIT_LOAD;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - CNT_ONE;
        end
      end
      STOP: begin
        // After a bad stop bit the line may still be low (break); park here
        // until it returns high so the tail is not taken as a new start bit.
        if (stop_wait) begin
          if (rx_sync) begin
            state_nxt     = IDLE;
            stop_wait_nxt = 1'b0;
          end
        end else if (tick) begin
          if (rx_sync) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt      = 1'b1;
            stop_wait_nxt = 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Receiver datapath registers. The error pulse is cleared whenever the
  // block is disabled so it can never stretch across a freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      frame     <= 8'd0;
      stop_wait <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= ena && ferr_nxt;
      if (ena) begin
        bit_cnt   <= bit_cnt_nxt;
        bit_idx   <= bit_idx_nxt;
        frame     <= frame_nxt;
        stop_wait <= stop_wait_nxt;
      end
    end
  end

  // Hamming decode of the assembled frame; positions 1..7 are code[0..6].
  logic [6:0] code, flip, fixed;
  logic [2:0] syn;
  logic [7:0] one_hot;
  logic       corr, unc;
  logic [8:0] entry;

  always_comb begin
    code    = frame[6:0];
    syn     = {code[3] ^ code[4] ^ code[5] ^ code[6],
               code[1] ^ code[2] ^ code[5] ^ code[6],
               code[0] ^ code[2] ^ code[4] ^ code[6]};
    // Bit 0 of the one-hot is the "no error" slot and is discarded.
    one_hot = 8'd1 << syn;
    flip    = one_hot[7:1];
`ifdef UART_SECDED_EN
    // Odd overall parity means an odd number of flips: treat as single.
    // Nonzero syndrome with even parity is a double error; leave raw bits.
    corr  = ^frame;
    unc   = (syn != 3'd0) && !(^frame);
    fixed = unc ? code : (code ^ flip);
`else
    corr  = (syn != 3'd0);
    unc   = 1'b0;
    fixed = code ^ flip;
`endif
    entry = {fixed[6], fixed[5], fixed[4], fixed[2], syn, corr, unc};
  end

  // Output FIFO. A push into a full FIFO still succeeds if the head pops
  // in the same cycle; otherwise the frame is dropped and flagged.
  logic [8:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] occ;
  logic            empty, full, pop, wr_en, drop;

  assign empty = (occ == '0);
  assign full  = (occ == FIFO_FULL);
  assign pop   = ena && !empty && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (ena && wr_en) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally because
  // the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else if (ena) begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && !pop) begin
        occ <= occ + OCC_ONE;
      end else if (pop && !wr_en) begin
        occ <= occ - OCC_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  logic [8:0] head;
  assign head = empty ? 9'd0 : mem[rd_ptr];

  assign out_valid         = !empty;
  assign out_data          = head[8:5];
  assign out_syndrome      = head[4:2];
  assign out_corrected     = head[1];
  assign out_uncorrectable = head[0];
  assign fifo_count        = occ;
  assign frame_err         = ferr_q && ena;
  assign state_out         = state;

endmodule
